// File: rtl/arb4_mux_ctrl.sv
// arb4_mux_ctrl: round-robin arbiter over four valid/grant requesters, driving a 4:1 word
// select into a registered valid/ready output stage. Rev 1.0
`default_nettype none

module arb4_mux_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic [3:0]       lock,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic [WIDTH-1:0] data3,
  output logic [3:0]       gnt,
  output logic [1:0]       sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t           state_q;
  logic [1:0]       ptr_q;
  logic [1:0]       ptr_d;
  logic [1:0]       sel_q;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  logic [1:0] win;
  logic [1:0] idx;
  logic       found;
  logic       load;
  logic       grant_en;

  // First requester at or after the pointer, scanning modulo 4.
  always_comb begin
    win   = ptr_q;
    idx   = ptr_q;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  assign load     = (state_q == S_EMPTY) || out_ready;
  assign grant_en = load && (|req) && !rst;
  assign gnt      = grant_en ? (4'b0001 << win) : 4'b0000;

  always_comb begin
    data_d = data0;
    case (win)
      2'd0:    data_d = data0;
      2'd1:    data_d = data1;
      2'd2:    data_d = data2;
      default: data_d = data3;
    endcase
  end

  // A locked winner keeps top priority for its next word.
  assign ptr_d = lock[win] ? win : win + 2'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_EMPTY;
      ptr_q   <= 2'd0;
      sel_q   <= 2'd0;
      data_q  <= '0;
    end else if (grant_en) begin
      state_q <= S_FULL;
      ptr_q   <= ptr_d;
      sel_q   <= win;
      data_q  <= data_d;
    end else if (state_q == S_FULL && out_ready) begin
      state_q <= S_EMPTY;
    end
  end

  assign out_valid = (state_q == S_FULL);
  assign out_data  = data_q;
  assign sel       = sel_q;

endmodule

`default_nettype wire

// File: doc/arb4_mux_ctrl.md
# arb4_mux_ctrl

Round-robin arbiter and output register that shares one 4:1 selection datapath among four requesters. Each requester offers a word with a valid/grant handshake. The controller picks one winner per cycle, steers its data through the 4:1 select, and holds the word in an output register behind a valid/ready handshake to a single consumer. It is the sequencing and ownership layer that sits in front of the 4-input multiplexer and drives it.

## Interface
- `WIDTH`, default 8: data width of each requester word and of `out_data`.

- `clk`  in  1  rising-edge clock; the only clock.
- `rst`  in  1  reset; synchronous, active-high.
- `req`  in  4  `req[i]` = requester i offers `data_i` this cycle.
- `lock`  in  4  `lock[i]` = requester i keeps top priority after its grant (burst).
- `data0`..`data3`  in  WIDTH each  requester words.
- `gnt`  out  4  one-hot/zero; `gnt[i]` = `data_i` captured at this clock edge.
- `sel`  out  2  index of the requester whose word is in `out_data`.
- `out_valid`  out  1  `out_data` holds a word.
- `out_data`  out  WIDTH  registered winning word.
- `out_ready`  in  1  consumer accepts `out_data` this cycle.

## Operation
- Per-requester handshake: a transfer happens on a cycle where `req[i]` and `gnt[i]` are both high.
  - Requester keeps `req` and `data` stable until granted.
  - It may keep `req` high after the grant to offer the next word.
- `load` = `!out_valid || out_ready`. The output register is empty, or is being drained this cycle.
- Winner selection:
  - Priority pointer `ptr` (2 bits).
  - Winner = first i with `req[i]` high, scanning `ptr`, `ptr+1`, `ptr+2`, `ptr+3` mod 4.
- `gnt` is combinational.
  - It equals one-hot(winner) when `load` and `|req` and `!rst`.
  - Otherwise it is 0.
  - At most one bit is high.
- On a clock edge with a grant:
  - `out_data` <= `data[winner]`, `sel` <= winner, `out_valid` <= 1.
  - `ptr` <= winner if `lock[winner]`, else winner+1 mod 4 (wraps 3 -> 0).
- On a clock edge with `out_valid && out_ready` and no grant: `out_valid` <= 0. `out_data` and `sel` hold their last values.
- On a clock edge with `out_valid && !out_ready`: all registers hold. `gnt` is 0.
- Implicit two-state machine:
  - EMPTY (`out_valid`=0): any req -> FULL.
  - FULL (`out_valid`=1):
    - `out_ready` and any req -> FULL (back-to-back reload).
    - `out_ready` and no req -> EMPTY.
    - `!out_ready` -> FULL (hold).
- Simultaneous drain and load in the same cycle replace the word. No bubble, no loss.
- `lock` is sampled only for the winner at the grant edge. `lock` of non-winners is ignored.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `sel`=0, `ptr`=0. `gnt`=0 while `rst` is high.
- Latency: a word granted at edge N is visible on `out_data` with `out_valid`=1 after edge N.
- Throughput: one word per cycle while `out_ready` stays high and any `req` is present.
- Backpressure: while `out_valid` && `!out_ready`:
  - `out_data` and `sel` are stable.
  - `gnt` stays 0.
- Reset mid-operation:
  - A word held in the register is discarded: `out_valid` goes to 0 after the reset edge.
  - No grant is issued in a reset cycle.
  - `ptr` returns to 0.
- Fairness: with `lock`=0, any continuously requesting input is granted within 4 grants.

## Test plan
- Reset with `req`=4'b1111:
  - `gnt`=0 during reset.
  - After the reset edge: `out_valid`=0, `out_data`=0, `sel`=0.
- Round-robin, all `req` high, `out_ready`=1, `data0..3`=8'h10,8'h21,8'h32,8'h43, `lock`=0:
  - Grants go 0,1,2,3,0.
  - `out_data` is 10,21,32,43,10 on consecutive cycles.
  - `out_valid` stays 1.
- Backpressure: `req`=4'b0100, `data2`=8'hA5, `out_ready`=0 for 3 cycles:
  - One `gnt[2]` pulse.
  - `out_data`=A5, `sel`=2 held.
  - `gnt`=0 for 3 cycles.
  - `out_ready`=1 with `req`=0 -> `out_valid`=0 next cycle.
- Lock: `req`=4'b0011, `lock`=4'b0001, `out_ready`=1:
  - Requester 0 wins every cycle.
  - Drop `lock[0]` -> the next two grants are 0 then 1.
- Pointer wrap:
  - Grant requester 3 alone.
  - Then `req`=4'b1001 -> requester 0 wins (`ptr`=0).
- Reset mid-operation while FULL with `sel`=1:
  - Assert `rst` one cycle -> `out_valid`=0 and `ptr`=0.
  - The next grant with `req`=4'b1111 goes to requester 0.
